// File: rtl/fifob_wr_arbiter_pkg.sv
// Shared definitions for the FIFO B write arbiter: FSM encoding, header layout
// and the helper that assembles a packet header word.
package fifob_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int          LEN_W         = 8;
    localparam int          HDR_W         = 32;
    localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
    localparam int          HDR_MAGIC_LSB = 24;
    localparam int          HDR_ID_LSB    = 8;
    localparam int          HDR_ID_W      = 2;
    localparam int          HDR_LEN_LSB   = 0;

    // Header word: {magic, zero pad, id, payload length}.
    function automatic logic [HDR_W-1:0] make_header(input logic [HDR_ID_W-1:0] id,
                                                     input logic [LEN_W-1:0]    len);
        logic [HDR_W-1:0] hdr;
        hdr                             = '0;
        hdr[HDR_MAGIC_LSB +: 8]         = HDR_MAGIC;
        hdr[HDR_ID_LSB +: HDR_ID_W]     = id;
        hdr[HDR_LEN_LSB +: LEN_W]       = len;
        return hdr;
    endfunction

endpackage

// File: rtl/fifob_wr_arbiter_rr.sv
// Round-robin one-hot picker: searches upward from the requester after last_gnt
// and returns the first active request as a one-hot vector.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] winner
);

    logic [IW-1:0] idx;
    logic          found;

    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_gnt) + k) % NREQ);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifob_wr_arbiter.sv
// Arbitrates NREQ packet sources onto the single FIFO B write port: one header
// word followed by up to 255 payload words per grant, round-robin between sources.
module fifob_wr_arbiter
    import fifob_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   req_len,
    input  logic [NREQ*DW-1:0]  src_data,
    input  logic [NREQ-1:0]     src_valid,
    output logic [NREQ-1:0]     src_ready,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [DW-1:0]       FIFOB_IN,
    output logic                FIFOB_wen,
    input  logic                FIFOB_full,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [IW-1:0]     id;
    logic [IW-1:0]     last_gnt;
    logic [LEN_W-1:0]  remaining;

    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_idx;
    logic [LEN_W-1:0]  win_len;
    logic [DW-1:0]     sel_data;
    logic              sel_valid;
    logic              fire;
    logic [DW-1:0]     header;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req      (req),
        .last_gnt (last_gnt),
        .winner   (win_onehot)
    );

    // Winner index/length for arbitration, and the granted source's payload lane.
    always_comb begin
        win_idx   = '0;
        win_len   = '0;
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_onehot[i]) begin
                win_idx = IW'(i);
                win_len = req_len[LEN_W*i +: LEN_W];
            end
            if (id == IW'(i)) begin
                sel_data  = src_data[DW*i +: DW];
                sel_valid = src_valid[i];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (state == S_BURST) begin
            src_ready[id] = ~FIFOB_full;
        end
    end

    assign fire   = (state == S_BURST) && sel_valid && !FIFOB_full;
    assign busy   = (state != S_IDLE);
    assign header = DW'(make_header(HDR_ID_W'(id), remaining));

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state     <= S_IDLE;
            last_gnt  <= IW'(NREQ - 1);
            id        <= '0;
            remaining <= '0;
            gnt       <= '0;
            done      <= '0;
            FIFOB_wen <= 1'b0;
            FIFOB_IN  <= '0;
        end else begin
            FIFOB_wen <= 1'b0;
            done      <= '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state     <= S_GRANT;
                        id        <= win_idx;
                        remaining <= win_len;
                        last_gnt  <= win_idx;
                        gnt       <= win_onehot;
                    end
                end
                S_GRANT: begin
                    if (!FIFOB_full) begin
                        FIFOB_IN  <= header;
                        FIFOB_wen <= 1'b1;
                        if (remaining == '0) begin
                            state <= S_DONE;
                            gnt   <= '0;
                            done  <= gnt;
                        end else begin
                            state <= S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (fire) begin
                        FIFOB_IN  <= sel_data;
                        FIFOB_wen <= 1'b1;
                        remaining <= remaining - 1'b1;
                        // Last payload word: gnt drops and done pulses together in DONE.
                        if (remaining == LEN_W'(1)) begin
                            state <= S_DONE;
                            gnt   <= '0;
                            done  <= gnt;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifob_wr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized phases, compared
// against a packet-level model (round-robin order, header + payload stream).
module tb_fifob_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic                CLK = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*8-1:0]   req_len;
    logic [NREQ*DW-1:0]  src_data;
    logic [NREQ-1:0]     src_valid;
    logic [NREQ-1:0]     src_ready;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       FIFOB_IN;
    logic                FIFOB_wen;
    logic                FIFOB_full;
    logic                busy;

    fifob_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .gnt        (gnt),
        .done       (done),
        .FIFOB_IN   (FIFOB_IN),
        .FIFOB_wen  (FIFOB_wen),
        .FIFOB_full (FIFOB_full),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus controls
    logic [3:0]  model_mask;
    bit          req_on;
    bit          force_valid;
    bit          rand_full;
    int          valid_pct;
    int          lens[NREQ];
    int          src_seq[NREQ];
    bit          ready2_seen;

    // Packet-level reference model
    int          model_seq[NREQ];
    int          model_last;
    logic [31:0] exp_q[$];
    int          cur;
    bit          pkt_open;
    logic [31:0] last_word;
    logic [31:0] wr_log[$];
    int          done_count;

    function automatic logic [31:0] word_of(input int i, input int s);
        return {8'(i), 24'((s + 1) * 17)};
    endfunction

    function automatic int next_winner(input logic [3:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        if (pkt_open) model_seq[cur] -= exp_q.size();
        exp_q.delete();
        pkt_open   = 1'b0;
        model_last = NREQ - 1;
        last_word  = '0;
    endtask

    task automatic model_edge(input bit pf);
        logic [31:0] e;
        if (FIFOB_wen) begin
            check("wen_after_full", 64'(pf), 64'(0));
            wr_log.push_back(FIFOB_IN);
            if (exp_q.size() == 0 && model_mask != 0) begin
                cur        = next_winner(model_mask, model_last);
                model_last = cur;
                pkt_open   = 1'b1;
                exp_q.push_back({8'hA5, 14'd0, 2'(cur), 8'(lens[cur])});
                for (int j = 0; j < lens[cur]; j++)
                    exp_q.push_back(word_of(cur, model_seq[cur] + j));
                model_seq[cur] += lens[cur];
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("fifob_word", 64'(FIFOB_IN), 64'(e));
                last_word = e;
            end else begin
                check("idle_wen", 64'(FIFOB_wen), 64'(0));
            end
        end else begin
            check("fifob_hold", 64'(FIFOB_IN), 64'(last_word));
        end
        if (done != 0) begin
            check("done_id", 64'(done), 64'(4'b1 << cur));
            check("done_pkt_complete", 64'(exp_q.size()), 64'(0));
            pkt_open = 1'b0;
            done_count++;
        end else if (pkt_open) begin
            check("gnt_held", 64'(gnt), 64'(4'b1 << cur));
        end
        check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        logic [NREQ-1:0] fired;
        bit pf, pr;
        req = req_on ? model_mask : '0;
        if (rand_full) FIFOB_full = ($urandom_range(99) < 20);
        for (int i = 0; i < NREQ; i++) begin
            req_len[8*i +: 8]    = 8'(lens[i]);
            src_data[DW*i +: DW] = word_of(i, src_seq[i]);
            src_valid[i]         = !rst && (force_valid || ($urandom_range(99) < 32'(valid_pct)));
        end
        #1;
        if (!rst) begin
            check("ready_ungranted", 64'(src_ready & ~gnt), 64'(0));
            if (FIFOB_full) check("ready_full", 64'(src_ready), 64'(0));
            ready2_seen |= src_ready[2];
        end
        fired = src_valid & src_ready;
        pf    = FIFOB_full;
        pr    = rst;
        @(posedge CLK);
        #1;
        if (pr) begin
            check("reset_outputs", 64'({src_ready, gnt, done, FIFOB_wen, busy, FIFOB_IN}), 64'(0));
            model_reset();
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (fired[i]) src_seq[i]++;
            model_edge(pf);
        end
        @(negedge CLK);
    endtask

    task automatic run_until_done(input int target, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (done_count >= target) break;
            step();
        end
        check("done_reached", 64'(done_count), 64'(target));
    endtask

    task automatic run_until_log(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (wr_log.size() >= n) break;
            step();
        end
        check("log_reached", 64'(wr_log.size()), 64'(n));
    endtask

    task automatic drain();
        req_on      = 1'b0;
        rand_full   = 1'b0;
        FIFOB_full  = 1'b0;
        force_valid = 1'b1;
        for (int c = 0; c < 600; c++) begin
            step();
            if (!busy && exp_q.size() == 0) break;
        end
        check("drain_busy", 64'(busy), 64'(0));
        check("drain_queue", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc0;
        rst = 1'b1; FIFOB_full = 1'b0; req = '0; req_len = '0;
        src_data = '0; src_valid = '0;
        model_mask = '0; req_on = 1'b0; force_valid = 1'b0; rand_full = 1'b0;
        valid_pct = 70; done_count = 0; cur = 0; pkt_open = 1'b0; ready2_seen = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            lens[i] = 0; src_seq[i] = 0; model_seq[i] = 0;
        end
        model_reset();
        @(negedge CLK);
        step();
        step();
        rst = 1'b0;

        // Single 3-word packet from requester 0
        model_mask = 4'b0001; lens[0] = 3; force_valid = 1'b1; req_on = 1'b1;
        wr_log.delete();
        run_until_done(1, 60);
        drain();
        check("t1_len", 64'(wr_log.size()), 64'(4));
        check("t1_hdr", 64'(wr_log[0]), 64'(32'hA5000003));
        check("t1_w1", 64'(wr_log[1]), 64'(32'h11));
        check("t1_w2", 64'(wr_log[2]), 64'(32'h22));
        check("t1_w3", 64'(wr_log[3]), 64'(32'h33));
        check("t1_done_count", 64'(done_count), 64'(1));

        // All four requesting, len=1: fair rotation from requester 0
        rst = 1'b1; step(); rst = 1'b0;
        model_mask = 4'b1111;
        for (int i = 0; i < NREQ; i++) lens[i] = 1;
        wr_log.delete(); dc0 = done_count; req_on = 1'b1;
        run_until_done(dc0 + 5, 200);
        drain();
        check("t2_len", 64'(wr_log.size()), 64'(10));
        check("t2_hdr0", 64'(wr_log[0]), 64'(32'hA5000001));
        check("t2_hdr1", 64'(wr_log[2]), 64'(32'hA5000101));
        check("t2_hdr2", 64'(wr_log[4]), 64'(32'hA5000201));
        check("t2_hdr3", 64'(wr_log[6]), 64'(32'hA5000301));
        check("t2_hdr4", 64'(wr_log[8]), 64'(32'hA5000001));

        // Zero-length packet on requester 2
        model_mask = 4'b0100;
        for (int i = 0; i < NREQ; i++) lens[i] = 0;
        wr_log.delete(); dc0 = done_count; ready2_seen = 1'b0; req_on = 1'b1;
        run_until_done(dc0 + 1, 60);
        drain();
        check("t3_len", 64'(wr_log.size()), 64'(1));
        check("t3_hdr", 64'(wr_log[0]), 64'(32'hA5000200));
        check("t3_ready2", 64'(ready2_seen), 64'(0));

        // Five-cycle FIFO B stall in the middle of an 8-word burst
        model_mask = 4'b0001; lens[0] = 8;
        wr_log.delete(); dc0 = done_count; req_on = 1'b1; force_valid = 1'b1;
        run_until_log(4, 60);
        FIFOB_full = 1'b1;
        repeat (5) begin
            step();
            check("stall_wen", 64'(FIFOB_wen), 64'(0));
        end
        FIFOB_full = 1'b0;
        run_until_done(dc0 + 1, 60);
        drain();
        check("t4_len", 64'(wr_log.size()), 64'(9));

        // Reset after 2 of 4 payload words; next grant restarts at requester 0
        model_mask = 4'b0001; lens[0] = 4;
        wr_log.delete(); req_on = 1'b1;
        run_until_log(3, 60);
        dc0 = done_count;
        rst = 1'b1; step(); rst = 1'b0;
        model_mask = 4'b0011; lens[1] = 4;
        wr_log.delete();
        run_until_log(1, 20);
        check("t5_hdr", 64'(wr_log[0]), 64'(32'hA5000004));
        check("t5_no_done", 64'(done_count), 64'(dc0));
        drain();

        // Randomized phases: random masks, lengths, valid and full
        for (int p = 0; p < 15; p++) begin
            model_mask = 4'($urandom_range(15, 1));
            for (int i = 0; i < NREQ; i++) lens[i] = $urandom_range(6, 0);
            force_valid = 1'b0; rand_full = 1'b1; req_on = 1'b1;
            repeat (80) step();
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifob_wr_arbiter.md
FIFOB_WR_ARBITER -- requirements
Module: fifob_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the FIFO B write port.
REQ-002 Parameter DW, default 32: data word width, equal to the FIFO B word width.
REQ-003 CLK  input  1  process clock; one clock domain, all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester packet request; level signal.
REQ-006 req_len  input  NREQ*8  per-requester payload word count, slice i = bits [8i+7:8i].
REQ-007 src_data  input  NREQ*DW  per-requester payload word, slice i = bits [DW*i+DW-1:DW*i].
REQ-008 src_valid  input  NREQ  per-requester payload word valid.
REQ-009 src_ready  output  NREQ  per-requester payload word accepted; combinational.
REQ-010 gnt  output  NREQ  one-hot grant; high from the GRANT state through the last BURST cycle.
REQ-011 done  output  NREQ  one-cycle pulse when the granted packet is complete.
REQ-012 FIFOB_IN  output  DW  word written to FIFO B; registered.
REQ-013 FIFOB_wen  output  1  FIFO B write enable; registered; one word per high cycle.
REQ-014 FIFOB_full  input  1  FIFO B programmable-full; asserted with at least 2 free entries of margin.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The state machine SHALL have states IDLE, GRANT, BURST and DONE, held in a 2-bit register.
REQ-017 IDLE: when any req bit is high, the next state SHALL be GRANT, with the winner chosen round-robin starting at last_gnt+1 modulo NREQ.
REQ-018 On entry to GRANT, the block SHALL latch winner id, req_len[winner] into an 8-bit remaining counter, and last_gnt<=winner.
REQ-019 GRANT: if FIFOB_full=0, the block SHALL write the header {8'hA5, 14'd0, id[1:0], len[7:0]} on the next edge (FIFOB_wen=1) and move to BURST, or to DONE if len=0; if FIFOB_full=1 it SHALL stay in GRANT.
REQ-020 BURST: src_ready[id] SHALL equal ~FIFOB_full; fire = src_valid[id] & src_ready[id].
REQ-021 On fire, the block SHALL register FIFOB_IN<=src_data[id], FIFOB_wen<=1 and decrement remaining, giving one cycle of latency from fire to write.
REQ-022 On a fire with remaining=1, the next state SHALL be DONE.
REQ-023 DONE: done[id] SHALL be high for exactly this one cycle and gnt SHALL be 0; the next state SHALL be IDLE.
REQ-024 src_ready SHALL be 0 for non-granted requesters and in all states other than BURST; their src_valid SHALL be ignored.
REQ-025 FIFOB_wen SHALL be 0 in any cycle not following a header write or a fire, and FIFOB_IN SHALL hold its last value when FIFOB_wen=0.
REQ-026 Deasserting req mid-packet SHALL NOT abort the packet; changes to req_len after it is latched SHALL be ignored.
REQ-027 A requester whose req is still high in DONE SHALL be eligible again only after the other requesters in round-robin order, giving no back-to-back grant while others wait.
REQ-028 FIFOB_full rising in the same cycle as src_valid SHALL block the transfer (no fire), and the word SHALL be accepted once full falls.
REQ-029 Maximum packet length SHALL be 255 payload words plus 1 header word.

Reset
REQ-030 While rst=1, the block SHALL set state=IDLE, last_gnt=NREQ-1 (so requester 0 wins first), remaining=0, gnt=0, done=0, FIFOB_wen=0, FIFOB_IN=0 and busy=0.
REQ-031 Reset mid-packet SHALL abandon the packet immediately; words already written stay in FIFO B and no done pulse is issued.

Structure
REQ-032 A shared package SHALL hold the state encoding, the header magic 8'hA5, the header field positions and the length width of 8.
REQ-033 One sub-module, rr_arbiter (NREQ-wide round-robin one-hot picker: inputs req and last_gnt, output one-hot winner), SHALL be instantiated; everything else stays in fifob_wr_arbiter.

Verification
REQ-034 After reset, req=4'b0001 with len=3 and data 11,22,33 always valid -> FIFOB sequence A5000003, 11, 22, 33; done[0] pulses once; busy returns to 0.
REQ-035 req=4'b1111 held, each len=1 -> headers in id order 0,1,2,3,0; each grant is one-hot and no two grants overlap.
REQ-036 len=0 on requester 2 -> single header A5000200, then DONE; src_ready[2] is never high.
REQ-037 FIFOB_full=1 for 5 cycles mid-burst with src_valid high -> no FIFOB_wen during the stall, no word lost or duplicated, payload order preserved.
REQ-038 rst pulsed during BURST after 2 of 4 words -> all outputs 0 next cycle; next grant goes to requester 0 with a fresh header.
REQ-039 src_valid toggled on a non-granted requester during a burst -> its src_ready stays 0 and FIFO B contents are unaffected.
